// File: rtl/bp_pkg.sv
// Shared types and helpers for the two-level branch history predictor.
package bp_pkg;

    // Width of the accepted-update and mispredict statistic counters.
    localparam int STAT_W = 32;

    // Predictor life cycle: table sweep after reset, then live.
    typedef enum logic {
        BP_INIT  = 1'b0,
        BP_READY = 1'b1
    } bp_state_e;

    // Weakly-not-taken counter value: 2^(ctr_bits-1) - 1.
    function automatic int unsigned bp_cinit(input int unsigned ctr_bits);
        return (32'd1 << (ctr_bits - 32'd1)) - 32'd1;
    endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Combinational saturating up/down step for one prediction counter.
module bp_sat_ctr #(
    parameter int CTR_BITS = 2
) (
    input  logic [CTR_BITS-1:0] value_i,
    input  logic                dir_i,    // 1 = count towards taken
    output logic [CTR_BITS-1:0] next_o
);

    // Step one position in the requested direction, holding at either end.
    always_comb begin
        next_o = value_i;
        if (dir_i) begin
            if (value_i != '1) next_o = value_i + 1'b1;
        end else begin
            if (value_i != '0) next_o = value_i - 1'b1;
        end
    end

endmodule

// File: rtl/bp_hist_predictor.sv
// Two-level branch direction predictor: counter table indexed by
// {pc slice, history}. History is per-PC (GLOBAL_HIST=0) or one shared
// register (GLOBAL_HIST=1). After reset the tables are swept clean before
// the predictor reports ready. Optional statistics are built only when
// the macro BP_STATS_EN is defined; otherwise the stat ports read zero.
module bp_hist_predictor
    import bp_pkg::*;
#(
    parameter int PC_BITS     = 5,
    parameter int HIST_BITS   = 3,
    parameter int CTR_BITS    = 2,
    parameter int GLOBAL_HIST = 0
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [PC_BITS-1:0] lookup_pc,
    output logic               predict,
    output logic               ready,
    input  logic               upd_we,
    input  logic [PC_BITS-1:0] upd_pc,
    input  logic               upd_taken,
    input  logic               upd_mispred,
    output logic [STAT_W-1:0]  stat_updates,
    output logic [STAT_W-1:0]  stat_mispreds
);

    localparam int IW   = PC_BITS + HIST_BITS;
    localparam int NCTR = 1 << IW;
    localparam int NPC  = 1 << PC_BITS;
    localparam logic [CTR_BITS-1:0] CINIT = CTR_BITS'(bp_cinit(CTR_BITS));

    bp_state_e            state_q, state_d;
    logic [IW-1:0]        sweep_q, sweep_d;
    logic [CTR_BITS-1:0]  ctr_q [NCTR];

    logic [HIST_BITS-1:0] lk_hist;
    logic [HIST_BITS-1:0] upd_hist;
    logic [HIST_BITS:0]   hist_ext;
    logic [HIST_BITS-1:0] hist_shift;
    logic [IW-1:0]        lk_idx;
    logic [IW-1:0]        upd_idx;
    logic [CTR_BITS-1:0]  ctr_next;
    logic                 in_init;
    logic                 accept;

    assign in_init    = (state_q == BP_INIT);
    assign ready      = (state_q == BP_READY);
    assign accept     = ready & upd_we;
    assign hist_ext   = {upd_hist, upd_taken};
    assign hist_shift = hist_ext[HIST_BITS-1:0];
    assign lk_idx     = {lookup_pc, lk_hist};
    assign upd_idx    = {upd_pc, upd_hist};
    // No bypass: a lookup racing an update sees the pre-update counter.
    assign predict    = ready & ctr_q[lk_idx][CTR_BITS-1];

    // Sweep every counter once after reset, then go live.
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        if (in_init) begin
            sweep_d = sweep_q + 1'b1;
            if (sweep_q == '1) state_d = BP_READY;
        end
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= BP_INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    bp_sat_ctr #(.CTR_BITS(CTR_BITS)) u_sat_ctr (
        .value_i (ctr_q[upd_idx]),
        .dir_i   (upd_taken),
        .next_o  (ctr_next)
    );

    // Counter table: sweep write during INIT, training write once live.
    always_ff @(posedge clk) begin
        if (in_init) begin
            ctr_q[sweep_q] <= CINIT;
        end else if (upd_we) begin
            ctr_q[upd_idx] <= ctr_next;
        end
    end

    generate
        if (GLOBAL_HIST != 0) begin : g_global
            logic [HIST_BITS-1:0] ghr_q, ghr_d;

            assign lk_hist  = ghr_q;
            assign upd_hist = ghr_q;

            // Shared history shifts on every accepted update.
            always_comb begin
                ghr_d = ghr_q;
                if (in_init)     ghr_d = '0;
                else if (upd_we) ghr_d = hist_shift;
            end

            // Global history register.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) ghr_q <= '0;
                else       ghr_q <= ghr_d;
            end
        end else begin : g_local
            logic [HIST_BITS-1:0] hist_q [NPC];

            assign lk_hist  = hist_q[lookup_pc];
            assign upd_hist = hist_q[upd_pc];

            // Per-PC history: cleared by the first NPC sweep steps, then trained.
            always_ff @(posedge clk) begin
                if (in_init) begin
                    if (sweep_q[IW-1:PC_BITS] == '0)
                        hist_q[sweep_q[PC_BITS-1:0]] <= '0;
                end else if (upd_we) begin
                    hist_q[upd_pc] <= hist_shift;
                end
            end
        end
    endgenerate

`ifdef BP_STATS_EN
    logic [STAT_W-1:0] upd_cnt_q, upd_cnt_d;
    logic [STAT_W-1:0] mis_cnt_q, mis_cnt_d;

    // Saturating event counters for accepted updates and mispredicts.
    always_comb begin
        upd_cnt_d = upd_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (accept) begin
            if (upd_cnt_q != '1)                upd_cnt_d = upd_cnt_q + 1'b1;
            if (upd_mispred && mis_cnt_q != '1) mis_cnt_d = mis_cnt_q + 1'b1;
        end
    end

    // Statistic registers, cleared only by reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            upd_cnt_q <= '0;
            mis_cnt_q <= '0;
        end else begin
            upd_cnt_q <= upd_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign stat_updates  = upd_cnt_q;
    assign stat_mispreds = mis_cnt_q;
`else
    logic unused_stats;
    assign unused_stats  = accept ^ upd_mispred;
    assign stat_updates  = '0;
    assign stat_mispreds = '0;
`endif

endmodule

// File: doc/bp_hist_predictor.md
# bp_hist_predictor

Parametrised two-level branch direction predictor for the IF stage of the RV32 pipeline. It indexes a table of saturating counters with a PC slice concatenated with branch history. History is either per-branch (local) or a single shared register (global), selected by parameter. After reset it runs a self-clearing sweep of its tables and only then reports ready. Predictions are combinational for the fetch stage; updates come from the EX stage on branch resolution.

## Interface
- PC_BITS, 5, width of the PC index slice (caller supplies pc[PC_BITS+1:2])
- HIST_BITS, 3, history length in outcomes
- CTR_BITS, 2, saturating counter width (≥2)
- GLOBAL_HIST, 0, 0 = per-PC local history table, 1 = single global history register
- clk  in  1  clock; single clock domain
- rstn  in  1  reset, asynchronous, active-low
- lookup_pc  in  PC_BITS  fetch-stage PC index
- predict  out  1  predicted taken
- ready  out  1  tables initialised, predictor live
- upd_we  in  1  branch resolved this cycle
- upd_pc  in  PC_BITS  PC index of the resolved branch
- upd_taken  in  1  actual outcome
- upd_mispred  in  1  predict given for this branch was wrong (stats only)
- stat_updates  out  32  accepted update count
- stat_mispreds  out  32  accepted mispredict count

## Operation
- Table index: IW = PC_BITS+HIST_BITS; idx = {pc, h}, where h = hist[pc] (local) or ghr (global).
- Counter init value CINIT = 2^(CTR_BITS-1)−1 (weakly not-taken, 01 for 2 bits); history init 0.
- predict = ready & ctr[{lookup_pc, h(lookup_pc)}][CTR_BITS−1].
- States: INIT, READY. Reset forces INIT and sweep = 0.
- INIT: each cycle writes ctr[sweep] = CINIT; when sweep < 2^PC_BITS also writes hist[sweep] = 0; ghr = 0. When sweep = 2^IW−1, go to READY. sweep wraps to 0.
- INIT ignores upd_we entirely: no table, history or stats change.
- READY, upd_we=1: i = {upd_pc, h(upd_pc)} using pre-update history.
  - taken: ctr[i] += 1 unless all ones.
  - not-taken: ctr[i] −= 1 unless zero.
  - History shifts left with upd_taken inserted at bit 0: hist[upd_pc] in local mode, ghr in global mode.
- Stats: stat_updates and stat_mispreds (the latter when upd_mispred=1) increment per accepted update, saturating at 2^32−1. Both are cleared only by reset.

## Timing
- Reset values: predict=0, ready=0, stat_*=0, state INIT.
- ready rises on the clock edge that completes the last sweep write, i.e. 2^IW cycles after rstn deasserts (256 for defaults).
- predict has zero latency: it is combinational from lookup_pc and the current table state.
- An update is visible from the next cycle. A same-cycle lookup of the entry being updated returns the old value; there is no bypass.
- A lookup in the cycle after an update uses the shifted history.
- rstn asserted mid-operation drops ready and predict immediately and restarts the sweep from 0.

## Configuration
- BP_STATS_EN defined: the stat counters are implemented as above.
- BP_STATS_EN undefined: the counter logic is absent, stat_updates and stat_mispreds are tied to 0, and the ports remain present.

## Structure
- Package bp_pkg: state enum (BP_INIT, BP_READY), STAT_W=32, a function computing CINIT from CTR_BITS.
- Sub-module bp_sat_ctr: a combinational CTR_BITS-wide saturating increment/decrement, taking value and dir and returning next.

## Test plan
- Reset release, defaults → ready=0 and predict=0 for 256 cycles; ready=1 on cycle 256. Every lookup then gives predict=0.
- upd_pc=5 taken ×5 → ctr{5,000}, ctr{5,001} and ctr{5,011} each = 10; ctr{5,111} = 11; lookup_pc=5 → predict=1.
- Continue: 3 more taken keep ctr{5,111}=11. Then 1 not-taken → ctr{5,111}=10, hist[5]=110, lookup_pc=5 → predict=0.
- upd_we pulsed during INIT → after ready, every counter = 01, every history = 0, stat_updates=0.
- Same-cycle lookup and update on pc 5 → predict reflects the pre-update value. The next cycle reflects the new value.
- BP_STATS_EN: 10 updates, 3 with upd_mispred → stat_updates=10, stat_mispreds=3. Mid-run rstn → ready=0 at once, stats 0, a fresh 256-cycle sweep. Without the macro both stats read 0.
